icache_mem_rd_responder: RTL
============================

Name: icache_mem_rd_responder

Overview:
- Memory-side responder for the I-cache refill read interface: accepts one 32-byte-aligned line read request and returns the line as an 8-beat burst of 32-bit words, with valid/ready per beat and a last flag.
- Backed by an internal word-addressed RAM, preloaded through a separate write port.
- Sits between the I-cache and the instruction memory model in simulation and FPGA bring-up.
- Also serves as the reference slave for I-cache verification.

Parameters:
MEM_ADDR_WIDTH, 10, word-address width of the internal RAM (2^MEM_ADDR_WIDTH 32-bit words).
RD_LATENCY, 2, cycles from request acceptance to the first beat's valid; legal range 1..15.

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
from_cache_rd_req_valid  input  1  line read request valid
from_cache_rd_req_addr  input  32  byte address; bits [4:0] ignored
to_cache_rd_req_ready  output  1  responder can accept a request
to_cache_rd_rsp_valid  output  1  current beat valid
to_cache_rd_rsp_data  output  32  current beat data
to_cache_rd_rsp_last  output  1  current beat is beat 7
from_cache_rd_rsp_ready  input  1  cache accepts current beat
init_wen  input  1  RAM preload write enable
init_addr  input  MEM_ADDR_WIDTH  RAM preload word address
init_wdata  input  32  RAM preload data

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE; beat counter, latency counter and output data register clear to 0. While rst=0: to_cache_rd_req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0. RAM contents are not cleared.
- States: IDLE, LAT, SEND. Encoding is one-hot.
- IDLE:
  - to_cache_rd_req_ready=1 (when rst=1).
  - On valid&ready at edge T: latch line base word index = addr[MEM_ADDR_WIDTH+1:5] concatenated with 3'b000. Address bits above MEM_ADDR_WIDTH+1 are ignored (aliasing modulo RAM size).
  - Clear beat counter to 0.
  - If RD_LATENCY=1, load beat 0 and go to SEND; otherwise go to LAT with latency counter = RD_LATENCY-2.
- LAT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each cycle.
  - When the counter is 0, load beat 0 and go to SEND.
  - Result: rsp_valid first asserts RD_LATENCY cycles after T.
- SEND:
  - rsp_valid=1; rsp_last=1 exactly when the beat counter is 7; req_ready=0.
  - rsp_data holds RAM[base+cnt].
  - While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_last are held stable.
  - Handshake on a non-last beat: cnt+1, load next word; the next beat is valid in the following cycle (no bubble).
  - Handshake on the last beat: go to IDLE; req_ready=1 in the following cycle.
  - Consecutive bursts never overlap.
- Loading beat k: rsp_data is registered from RAM[base+k] at the edge where beat k is loaded. Beat 0 loads on the edge entering SEND; beat k>0 loads on the edge of beat k-1's handshake.
- Init port:
  - When init_wen=1, RAM[init_addr] <= init_wdata at the edge. Active in any state.
  - If the write hits the word being loaded on the same edge, the old value is returned (read-before-write).
  - Writes to words of the line that land earlier are visible to later beats.
- Requests arriving while not in IDLE are not accepted (ready=0). from_cache_rd_req_addr is only sampled at acceptance.
- Reset mid-burst: the burst is aborted immediately. After rst returns to 1, the block is in IDLE with req_ready=1 and no stale beat is emitted.
- Beat counter is 3 bits. The wrap from 7 is never used because last terminates the burst.

Test Plan:
- Preload RAM[w]=0xA000_0000+w for w=0..1023; RD_LATENCY=2; request addr 0x0000_0040 accepted at edge T, rsp_ready=1 -> rsp_valid high T+2..T+9 with data 0xA0000010..0xA0000017; last only at T+9; req_ready=1 at T+10.
- Same preload; request addr 0x0000_005C -> identical burst to addr 0x40 (low 5 bits ignored); request 0x0000_1040 with MEM_ADDR_WIDTH=10 -> also words 16..23 (aliasing).
- Backpressure: deassert rsp_ready for 3 cycles on beat 2 and for 1 cycle on beat 7 -> data 0xA0000012 and 0xA0000017 held stable with valid=1 throughout; total burst occupies 12 valid cycles; exactly 8 handshakes.
- RD_LATENCY=1, two back-to-back requests (0x0, 0x20) with req_valid held high -> first beat one cycle after acceptance; second request accepted only the cycle after the first burst's last handshake; data words 0..7 then 8..15.
- Reset mid-burst: assert rst=0 asynchronously after beat 3 handshake -> rsp_valid, rsp_last, rsp_data and req_ready go 0 without waiting for a clock edge; after release, a new request to 0x80 returns 0xA0000020..27 correctly.
- Init write during burst: during beat 1 stall, write RAM[21]=0xDEAD_BEEF for request 0x40 -> beat 5 returns 0xDEADBEEF; a write to RAM[17] on the edge that loads beat 1 -> beat 1 returns old 0xA0000011.

Source files
------------

// File: rtl/icache_mem_rd_responder.sv
// I-cache refill responder: accepts a 32-byte line read and returns it as an
// 8-beat burst of 32-bit words from an internal RAM preloaded via an init port.
module icache_mem_rd_responder #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      from_cache_rd_req_valid,
    input  logic [31:0]               from_cache_rd_req_addr,
    output logic                      to_cache_rd_req_ready,
    output logic                      to_cache_rd_rsp_valid,
    output logic [31:0]               to_cache_rd_rsp_data,
    output logic                      to_cache_rd_rsp_last,
    input  logic                      from_cache_rd_rsp_ready,
    input  logic                      init_wen,
    input  logic [MEM_ADDR_WIDTH-1:0] init_addr,
    input  logic [31:0]               init_wdata
);

    localparam int unsigned AW       = MEM_ADDR_WIDTH;
    localparam int unsigned LW       = AW - 3;
    localparam int unsigned DEPTH    = 1 << AW;
    localparam int unsigned LATW     = 4;
    localparam logic [LATW-1:0] LAT_INIT = LATW'((RD_LATENCY >= 2) ? (RD_LATENCY - 2) : 0);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        LAT  = 3'b010,
        SEND = 3'b100
    } state_t;

    state_t          state_q;
    logic [LW-1:0]   line_q;
    logic [2:0]      cnt_q;
    logic [LATW-1:0] lat_q;
    logic [31:0]     data_q;
    logic [31:0]     mem_q [DEPTH];

    logic [LW-1:0]   req_line_c;
    logic [AW-1:0]   rd_addr_c;
    logic            unused_addr_c;

    assign req_line_c    = from_cache_rd_req_addr[AW+1:5];
    assign unused_addr_c = ^{from_cache_rd_req_addr[31:AW+2], from_cache_rd_req_addr[4:0]};

    // Word to load on this edge: beat 0 of a new/pending line, else the next beat.
    always_comb begin
        rd_addr_c = {line_q, 3'(cnt_q + 3'd1)};
        case (state_q)
            IDLE:    rd_addr_c = {req_line_c, 3'b000};
            LAT:     rd_addr_c = {line_q, 3'b000};
            default: rd_addr_c = {line_q, 3'(cnt_q + 3'd1)};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (from_cache_rd_req_valid) begin
                        line_q <= req_line_c;
                        cnt_q  <= '0;
                        if (RD_LATENCY <= 1) begin
                            data_q  <= mem_q[rd_addr_c];
                            state_q <= SEND;
                        end else begin
                            lat_q   <= LAT_INIT;
                            state_q <= LAT;
                        end
                    end
                end
                LAT: begin
                    if (lat_q == '0) begin
                        data_q  <= mem_q[rd_addr_c];
                        state_q <= SEND;
                    end else begin
                        lat_q <= lat_q - LATW'(1);
                    end
                end
                SEND: begin
                    if (from_cache_rd_rsp_ready) begin
                        if (cnt_q == 3'd7) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q  <= cnt_q + 3'd1;
                            data_q <= mem_q[rd_addr_c];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Preload port; reads above sample the pre-write value on a colliding edge.
    always_ff @(posedge clk) begin
        if (init_wen) begin
            mem_q[init_addr] <= init_wdata;
        end
    end

    // Ready is gated by reset so it drops asynchronously and returns on release.
    assign to_cache_rd_req_ready = rst && (state_q == IDLE);
    assign to_cache_rd_rsp_valid = (state_q == SEND);
    assign to_cache_rd_rsp_last  = (state_q == SEND) && (cnt_q == 3'd7);
    assign to_cache_rd_rsp_data  = data_q;

endmodule
